// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle controller's unified memory port.
// Accepts one word-addressed read or write at a time, waits WAIT_CYCLES clocks,
// performs the access, then holds the response until the initiator takes it.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_write/req_addr/req_wdata   request fields, sampled at acceptance
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err              registered response (rdata 0 for writes/errors)
//   txn_count                      completed response handshakes, wraps at 16 bits
module mem_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       txn_count
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [15:0]         txn_q;

  logic                accept;
  logic                enter_resp;
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                in_range;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Handshake outputs come from the state register; rst only forces them low.
  assign req_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = (state_q == StResp) && !rst;
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the acceptance edge itself, so
  // the live request fields are used instead of the not-yet-latched copies.
  assign acc_write = (state_q == StIdle) ? req_write : write_q;
  assign acc_addr  = (state_q == StIdle) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
  assign in_range  = 32'(acc_addr) < DEPTH;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 8'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        if (cnt_q == 8'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
          cnt_d      = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      txn_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        if (!in_range) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (acc_write) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
          rdata_q <= mem[acc_addr];
          err_q   <= 1'b0;
        end
      end
      if (state_q == StResp && rsp_ready) txn_q <= txn_q + 16'd1;
    end
  end

  // Memory is deliberately outside the reset domain; a reset mid-WAIT drops
  // the pending write because enter_resp is masked by rst here.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && in_range && acc_write) mem[acc_addr] <= acc_wdata;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: two wait states, 200 implemented words
  logic        req_valid_a, req_ready_a, req_write_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
  logic [7:0]  req_addr_a;
  logic [15:0] req_wdata_a, rsp_rdata_a, txn_count_a;
  // DUT B: zero wait states, full 256 words
  logic        req_valid_b, req_ready_b, req_write_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [7:0]  req_addr_b;
  logic [15:0] req_wdata_b, rsp_rdata_b, txn_count_b;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_rdata(rsp_rdata_a),
    .rsp_err(rsp_err_a), .txn_count(txn_count_a)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .txn_count(txn_count_b)
  );

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [256];
  logic [15:0] txn_exp_a;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on DUT A; hold = cycles to stall the response.
  task automatic txn_a(input string tag, input logic w, input logic [7:0] addr,
                       input logic [15:0] wd, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(req_ready_a), 32'd1);
    req_valid_a = 1'b1;
    req_write_a = w;
    req_addr_a  = addr;
    req_wdata_a = wd;
    if (addr >= 8'd200) begin
      e = '{rdata: 16'h0, err: 1'b1};
    end else if (w) begin
      e = '{rdata: 16'h0, err: 1'b0};
      model[addr] = wd;
    end else begin
      e = '{rdata: model[addr], err: 1'b0};
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Scramble request fields to show they were latched at acceptance.
    req_valid_a = 1'b0;
    req_write_a = ~w;
    req_addr_a  = ~addr;
    req_wdata_a = 16'hDEAD;
    n = 0;
    while (!rsp_valid_a && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd2);
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " rdata"}, 32'(rsp_rdata_a), 32'(e.rdata));
      check({tag, " err"}, 32'(rsp_err_a), 32'(e.err));
    end
    for (int i = 0; i < hold; i++) begin
      req_valid_a = (i % 2) == 0;
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold_valid"}, 32'(rsp_valid_a), 32'd1);
      check({tag, " hold_rdata"}, 32'(rsp_rdata_a), 32'(e.rdata));
      check({tag, " hold_ready"}, 32'(req_ready_a), 32'd0);
    end
    req_valid_a = 1'b0;
    rsp_ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_a = 1'b0;
    txn_exp_a++;
    check({tag, " done_valid"}, 32'(rsp_valid_a), 32'd0);
    check({tag, " done_ready"}, 32'(req_ready_a), 32'd1);
    check({tag, " txn_count"}, 32'(txn_count_a), 32'(txn_exp_a));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    {req_valid_a, req_write_a, rsp_ready_a} = '0;
    {req_valid_b, req_write_b, rsp_ready_b} = '0;
    req_addr_a = '0; req_wdata_a = '0; req_addr_b = '0; req_wdata_b = '0;
    txn_exp_a = 16'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready_a", 32'(req_ready_a), 32'd0);
    check("rst req_ready_b", 32'(req_ready_b), 32'd0);
    check("rst rsp_valid_a", 32'(rsp_valid_a), 32'd0);
    check("rst rsp_rdata_a", 32'(rsp_rdata_a), 32'd0);
    check("rst rsp_err_a", 32'(rsp_err_a), 32'd0);
    check("rst txn_count_a", 32'(txn_count_a), 32'd0);
    rst = 1'b0;

    // rsp_ready while idle must not count anything
    rsp_ready_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rsp_ready_a = 1'b0;
    check("idle rsp_ready txn", 32'(txn_count_a), 32'd0);
    check("idle rsp_valid", 32'(rsp_valid_a), 32'd0);

    txn_a("t1_wr", 1'b1, 8'h10, 16'hBEEF, 0);
    txn_a("t2_rd", 1'b0, 8'h10, 16'h0000, 0);
    txn_a("t3_hold", 1'b0, 8'h10, 16'h0000, 5);
    txn_a("t4_wr_oor", 1'b1, 8'hC8, 16'h7777, 0);
    txn_a("t4_rd_oor", 1'b0, 8'hC8, 16'h0000, 0);
    txn_a("edge_wr", 1'b1, 8'hC7, 16'h1357, 0);
    txn_a("edge_rd", 1'b0, 8'hC7, 16'h0000, 0);
    txn_a("raw_wr1", 1'b1, 8'h10, 16'hCAFE, 0);
    txn_a("raw_rd1", 1'b0, 8'h10, 16'h0000, 0);
    txn_a("pre_wr5", 1'b1, 8'h05, 16'h0A0A, 0);

    // Reset in the middle of WAIT for a write that must never land
    @(negedge clk);
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 8'h05; req_wdata_a = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0;
    check("t5 in_wait valid", 32'(rsp_valid_a), 32'd0);
    rst = 1'b1;
    #1;
    check("t5 rst req_ready", 32'(req_ready_a), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    txn_exp_a = 16'd0;
    check("t5 post rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("t5 post req_ready", 32'(req_ready_a), 32'd1);
    check("t5 post txn_count", 32'(txn_count_a), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5 abandoned", 32'(rsp_valid_a), 32'd0);
    txn_a("t5_rd", 1'b0, 8'h05, 16'h0000, 0);

    // Zero wait states on DUT B
    @(negedge clk);
    req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 8'h03; req_wdata_b = 16'h5A5A;
    @(posedge clk);
    @(negedge clk);
    req_valid_b = 1'b0;
    check("t6 wr rsp_valid", 32'(rsp_valid_b), 32'd1);
    check("t6 wr rdata", 32'(rsp_rdata_b), 32'd0);
    check("t6 wr err", 32'(rsp_err_b), 32'd0);
    rsp_ready_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_b = 1'b0;
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 8'h03;
    @(posedge clk);
    @(negedge clk);
    req_valid_b = 1'b0;
    check("t6 rd rsp_valid", 32'(rsp_valid_b), 32'd1);
    check("t6 rd rdata", 32'(rsp_rdata_b), 32'h5A5A);
    check("t6 rd req_ready", 32'(req_ready_b), 32'd0);
    rsp_ready_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6 txn2", 32'(txn_count_b), 32'd2);
    check("t6 idle valid", 32'(rsp_valid_b), 32'd0);

    // Back-to-back handshakes: two edges per transaction up to the wrap
    req_valid_b = 1'b1;
    repeat (2 * (65536 - 3)) @(posedge clk);
    @(negedge clk);
    check("t6 txn ffff", 32'(txn_count_b), 32'hFFFF);
    check("t6 stream rdata", 32'(rsp_rdata_b), 32'h5A5A);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid_b = 1'b0;
    rsp_ready_b = 1'b0;
    check("t6 txn wrap", 32'(txn_count_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
